// File: rtl/spi_slave_mode_if.sv
// System-side handshake bundle for spi_slave_mode.
// The slave modport is the view of the SPI slave itself. The master modport is the
// view of the system_clk-domain logic that feeds TX words and consumes RX words.
// rx_level exists only when SPI_SLAVE_RX_FIFO_EN is defined.
interface spi_slave_mode_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              rx_overrun;
    logic              tx_underrun;
    logic              cs_abort;
    logic              busy;
`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [2:0]        rx_level;
`endif

    modport slave (
        input  tx_data, tx_valid, rx_ack,
        output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, cs_abort,
`ifdef SPI_SLAVE_RX_FIFO_EN
        output rx_level,
`endif
        output busy
    );

    modport master (
        output tx_data, tx_valid, rx_ack,
        input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, cs_abort,
`ifdef SPI_SLAVE_RX_FIFO_EN
        input  rx_level,
`endif
        input  busy
    );
endinterface

// File: rtl/spi_slave_mode.sv
// Parametrised SPI slave: any CPOL/CPHA mode, DATA_W-bit words, MSB- or LSB-first,
// multi-word frames under one chip-select. All logic runs on system_clk. The SPI
// pins are oversampled through synchronisers, so system_clk must be at least
// 8x spi_clk.
// Optional macro SPI_SLAVE_RX_FIFO_EN replaces the single RX register with a
// 4-entry FIFO and adds rx_level.
module spi_slave_mode #(
    parameter int unsigned       DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '1
) (
    input  logic            system_clk,
    input  logic            system_rst,
    input  logic            spi_clk,
    input  logic            spi_cs,
    input  logic            mosi,
    output logic            miso,
    spi_slave_mode_if.slave bus
);
    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   load_next_q, load_next_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   cs_abort_q, cs_abort_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   word_done, do_load;

    // Edges come from the two oldest synchroniser stages.
    logic sclk_new, sclk_old, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, mosi_s;
    assign sclk_new    = sclk_sync_q[SYNC_STAGES-2];
    assign sclk_old    = sclk_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sclk_old == CPOL) && (sclk_new != CPOL);
    assign trail_edge  = (sclk_old != CPOL) && (sclk_new == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_sync_q[SYNC_STAGES-1] && !cs_sync_q[SYNC_STAGES-2];
    assign cs_rise     = !cs_sync_q[SYNC_STAGES-1] && cs_sync_q[SYNC_STAGES-2];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    // Bring the asynchronous SPI pins into the system_clk domain.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    // Frame FSM, bit counter, shift registers and TX holding register.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        load_next_d   = load_next_q;
        tx_underrun_d = 1'b0;
        cs_abort_d    = 1'b0;
        word_done     = 1'b0;
        do_load       = 1'b0;

        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    do_load     = 1'b1;
                    bit_cnt_d   = '0;
                    load_next_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    cs_abort_d  = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    load_next_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                               : {mosi_s, rx_shift_q[DATA_W-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            word_done = 1'b1;
                            // CPHA=1 reloads now; CPHA=0 defers to the next shift edge.
                            if (CPHA) do_load = 1'b1;
                            else      load_next_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (!CPHA && load_next_q) begin
                            do_load     = 1'b1;
                            load_next_d = 1'b0;
                        end else if (!(CPHA && (bit_cnt_q == '0))) begin
                            tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                                   : {1'b0, tx_shift_q[DATA_W-1:1]};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = TX_IDLE;
                tx_underrun_d = 1'b1;
            end
        end
    end

    // State register for the frame FSM and TX/RX datapath.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            load_next_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            cs_abort_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            load_next_q   <= load_next_d;
            tx_underrun_q <= tx_underrun_d;
            cs_abort_q    <= cs_abort_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [DATA_W-1:0] fifo_q [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]        level_q, level_d;
    logic              push, pop;

    // RX FIFO pointer and occupancy update; a pop frees room for a same-cycle push.
    always_comb begin
        pop          = bus.rx_ack && (level_q != 3'd0);
        push         = word_done && ((level_q != 3'd4) || pop);
        rd_ptr_d     = rd_ptr_q + 2'(pop);
        wr_ptr_d     = wr_ptr_q + 2'(push);
        level_d      = level_q + 3'(push) - 3'(pop);
        rx_overrun_d = word_done && !push;
    end

    // RX FIFO storage and pointers.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) fifo_q[wr_ptr_q] <= rx_shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign bus.rx_data  = fifo_q[rd_ptr_q];
    assign bus.rx_valid = (level_q != 3'd0);
    assign bus.rx_level = level_q;
`else
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    // Single RX register: an ack in the same cycle makes room for the new word.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = 1'b0;
        if (word_done) begin
            if (!rx_valid_q || bus.rx_ack) begin
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    // RX data register.
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`endif

    assign bus.tx_ready    = !hold_full_q;
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.cs_abort    = cs_abort_q;
    assign bus.rx_overrun  = rx_overrun_q;

    // MISO is gated by the raw chip-select so the line releases without sync delay.
    assign miso = spi_cs ? 1'bz : (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
endmodule
